// File: rtl/paint_job_arbiter.sv
// paint_job_arbiter: round-robin sharing of one rectangle/circle paint engine
// between NUM_REQ paint sequencers using a level req / pulsed ack handshake.
// Optional WAIT-state watchdog is built only when PAINT_ARB_TIMEOUT_EN is defined.
module paint_job_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned X_BITS     = 8,
    parameter int unsigned Y_BITS     = 7,
    parameter int unsigned COLOR_BITS = 3,
    parameter int unsigned CFG_BITS   = 3,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic                           Clck,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*X_BITS-1:0]      req_x_start,
    input  logic [NUM_REQ*X_BITS-1:0]      req_x_end,
    input  logic [NUM_REQ*Y_BITS-1:0]      req_y_start,
    input  logic [NUM_REQ*Y_BITS-1:0]      req_y_end,
    input  logic [NUM_REQ*CFG_BITS-1:0]    req_cfg,
    input  logic [NUM_REQ*COLOR_BITS-1:0]  req_color,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [2:0]                     grant_id,
    output logic                           busy,
    output logic [X_BITS-1:0]              eng_x_start,
    output logic [X_BITS-1:0]              eng_x_end,
    output logic [Y_BITS-1:0]              eng_y_start,
    output logic [Y_BITS-1:0]              eng_y_end,
    output logic [CFG_BITS-1:0]            eng_cfg,
    output logic [COLOR_BITS-1:0]          eng_color,
    output logic                           eng_start,
    input  logic                           eng_done,
    output logic                           timeout_err
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [ID_W-1:0]         last_grant, last_grant_d;
    logic [ID_W-1:0]         grant_id_d;
    logic [ID_W-1:0]         win_id;
    logic                    win_found;
    logic                    busy_d;
    logic                    eng_start_d;
    logic [NUM_REQ-1:0]      req_ack_d;
    logic [NUM_REQ-1:0]      grant_onehot;
    logic [X_BITS-1:0]       x_start_d, x_end_d, win_x_start, win_x_end;
    logic [Y_BITS-1:0]       y_start_d, y_end_d, win_y_start, win_y_end;
    logic [CFG_BITS-1:0]     cfg_d, win_cfg;
    logic [COLOR_BITS-1:0]   color_d, win_color;

`ifdef PAINT_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_d;
    logic                    timeout_err_d;
`else
    logic [CNT_W-1:0]        unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    // Round-robin pick: first set req above last_grant, else wrap to the lowest set req
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && req[i] && (i > int'(last_grant))) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && req[i] && (i <= int'(last_grant))) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end

    // Select the winner's job fields out of the flattened request buses
    always_comb begin
        win_x_start = '0;
        win_x_end   = '0;
        win_y_start = '0;
        win_y_end   = '0;
        win_cfg     = '0;
        win_color   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_id == ID_W'(i)) begin
                win_x_start = req_x_start[i*X_BITS +: X_BITS];
                win_x_end   = req_x_end[i*X_BITS +: X_BITS];
                win_y_start = req_y_start[i*Y_BITS +: Y_BITS];
                win_y_end   = req_y_end[i*Y_BITS +: Y_BITS];
                win_cfg     = req_cfg[i*CFG_BITS +: CFG_BITS];
                win_color   = req_color[i*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    // One-hot of the job currently owning the engine, used for the ack
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant_onehot[i] = (grant_id == ID_W'(i));
        end
    end

    // Next-state and next-output logic; eng_* keep the last job while idle
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_id_d   = grant_id;
        busy_d       = busy;
        eng_start_d  = 1'b0;
        req_ack_d    = '0;
        x_start_d    = eng_x_start;
        x_end_d      = eng_x_end;
        y_start_d    = eng_y_start;
        y_end_d      = eng_y_end;
        cfg_d        = eng_cfg;
        color_d      = eng_color;
`ifdef PAINT_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt;
        timeout_err_d = timeout_err;
`endif
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    x_start_d   = win_x_start;
                    x_end_d     = win_x_end;
                    y_start_d   = win_y_start;
                    y_end_d     = win_y_end;
                    cfg_d       = win_cfg;
                    color_d     = win_color;
                    grant_id_d  = win_id;
                    busy_d      = 1'b1;
                    eng_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef PAINT_ARB_TIMEOUT_EN
                wait_cnt_d = TIMEOUT;
`endif
            end
            S_WAIT: begin
                if (eng_done) begin
                    req_ack_d = grant_onehot;
                    state_d   = S_DONE;
                end
`ifdef PAINT_ARB_TIMEOUT_EN
                else if (wait_cnt == '0) begin
                    req_ack_d     = grant_onehot;
                    timeout_err_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt - CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                last_grant_d = grant_id;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            grant_id    <= '0;
            busy        <= 1'b0;
            eng_start   <= 1'b0;
            req_ack     <= '0;
            eng_x_start <= '0;
            eng_x_end   <= '0;
            eng_y_start <= '0;
            eng_y_end   <= '0;
            eng_cfg     <= '0;
            eng_color   <= '0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            grant_id    <= grant_id_d;
            busy        <= busy_d;
            eng_start   <= eng_start_d;
            req_ack     <= req_ack_d;
            eng_x_start <= x_start_d;
            eng_x_end   <= x_end_d;
            eng_y_start <= y_start_d;
            eng_y_end   <= y_end_d;
            eng_cfg     <= cfg_d;
            eng_color   <= color_d;
        end
    end

`ifdef PAINT_ARB_TIMEOUT_EN
    // WAIT watchdog counter and sticky timeout flag
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_paint_job_arbiter.sv
// Bench for paint_job_arbiter: random requesters and engine, job scoreboard,
// round-robin reference model, plus directed scenarios.
module tb_paint_job_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int XB = 8;
    localparam int YB = 7;
    localparam int CB = 3;
    localparam int FB = 3;
    localparam int TO = 8;
    localparam int FW = 2*XB + 2*YB + FB + CB;

    typedef struct packed {
        logic [2:0]    id;
        logic [XB-1:0] xs;
        logic [XB-1:0] xe;
        logic [YB-1:0] ys;
        logic [YB-1:0] ye;
        logic [FB-1:0] cfg;
        logic [CB-1:0] col;
    } job_t;

    logic             Clck = 1'b0;
    logic             Reset;
    logic [NR-1:0]    req;
    logic [NR*XB-1:0] req_x_start, req_x_end;
    logic [NR*YB-1:0] req_y_start, req_y_end;
    logic [NR*FB-1:0] req_cfg;
    logic [NR*CB-1:0] req_color;
    logic [NR-1:0]    req_ack;
    logic [2:0]       grant_id;
    logic             busy;
    logic [XB-1:0]    eng_x_start, eng_x_end;
    logic [YB-1:0]    eng_y_start, eng_y_end;
    logic [FB-1:0]    eng_cfg;
    logic [CB-1:0]    eng_color;
    logic             eng_start;
    logic             eng_done;
    logic             timeout_err;

    paint_job_arbiter #(
        .NUM_REQ(NR), .X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .CFG_BITS(FB),
        .TIMEOUT(16'(TO))
    ) dut (
        .Clck(Clck), .Reset(Reset), .req(req),
        .req_x_start(req_x_start), .req_x_end(req_x_end),
        .req_y_start(req_y_start), .req_y_end(req_y_end),
        .req_cfg(req_cfg), .req_color(req_color),
        .req_ack(req_ack), .grant_id(grant_id), .busy(busy),
        .eng_x_start(eng_x_start), .eng_x_end(eng_x_end),
        .eng_y_start(eng_y_start), .eng_y_end(eng_y_end),
        .eng_cfg(eng_cfg), .eng_color(eng_color),
        .eng_start(eng_start), .eng_done(eng_done), .timeout_err(timeout_err)
    );

    always #5 Clck = ~Clck;

    int          errors = 0;
    int          checks = 0;
    job_t        exp_q[$];
    int          glog[$];
    int          ack_cnt = 0;
    int          eng_pend = 0;
    int          eng_delay = 0;
    bit          eng_hold = 0;
    logic [NR-1:0] keep_mask = '0;
    int unsigned p_new = 0;
    int unsigned p_keep = 0;

    // reference model state
    int mlast, cd, infl_id, g_iter, iter;
    bit mfree, infl, exp_terr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] job_f(input job_t j);
        return {j.xs, j.xe, j.ys, j.ye, j.cfg, j.col};
    endfunction

    function automatic logic [FW-1:0] dut_f();
        return {eng_x_start, eng_x_end, eng_y_start, eng_y_end, eng_cfg, eng_color};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req_ack, grant_id, busy, eng_start, timeout_err, dut_f()});
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.id  = '0;
        j.xs  = XB'($urandom);
        j.xe  = XB'($urandom);
        j.ys  = YB'($urandom);
        j.ye  = YB'($urandom);
        j.cfg = FB'($urandom_range(1, 0));
        j.col = CB'($urandom);
        return j;
    endfunction

    // first requester set, searching upward from last+1 modulo NR
    function automatic int rr_winner(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (r[IW'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic int find_job(input int id);
        foreach (exp_q[k]) if (int'(exp_q[k].id) == id) return k;
        return -1;
    endfunction

    task automatic issue(input int i, input job_t j);
        j.id = 3'(i);
        req_x_start[i*XB +: XB] = j.xs;
        req_x_end[i*XB +: XB]   = j.xe;
        req_y_start[i*YB +: YB] = j.ys;
        req_y_end[i*YB +: YB]   = j.ye;
        req_cfg[i*FB +: FB]     = j.cfg;
        req_color[i*CB +: CB]   = j.col;
        req[IW'(i)] = 1'b1;
        exp_q.push_back(j);
    endtask

    // Engine model: done pulses one cycle, eng_pend negedges after scheduling
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge Clck);
            eng_done = 1'b0;
            if (eng_pend > 0) begin
                eng_pend--;
                if (eng_pend == 0) eng_done = 1'b1;
            end
        end
    end

    // Requesters: hold req until ack, then maybe request again
    initial begin
        forever begin
            @(negedge Clck);
            if (Reset) begin
                for (int i = 0; i < NR; i++) begin
                    if (req[IW'(i)] && req_ack[IW'(i)]) begin
                        if (keep_mask[IW'(i)] || ($urandom_range(99, 0) < p_keep)) issue(i, rand_job());
                        else req[IW'(i)] = 1'b0;
                    end else if (!req[IW'(i)] && (p_new > 0) && ($urandom_range(99, 0) < p_new)) begin
                        issue(i, rand_job());
                    end
                end
            end
        end
    end

    // Monitor: predicts start/ack/busy per cycle and scoreboards job fields
    initial begin : monitor
        logic [NR-1:0] s_req;
        logic          s_done;
        logic [NR-1:0] exp_ack;
        logic          exp_start;
        int            w, idx;
        iter = 0;
        forever begin
            @(posedge Clck);
            s_req  = req;
            s_done = eng_done;
            #1;
            iter++;
            if (!Reset) begin
                mlast = NR - 1; mfree = 1; cd = 0; infl = 0; exp_terr = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) mfree = 1;
                end
                exp_ack = '0;
                if (infl && (iter >= g_iter + 2)) begin
                    if (s_done) exp_ack[IW'(infl_id)] = 1'b1;
`ifdef PAINT_ARB_TIMEOUT_EN
                    else if (iter - g_iter - 2 == TO) begin
                        exp_ack[IW'(infl_id)] = 1'b1;
                        exp_terr = 1;
                    end
`endif
                end
                chk("req_ack", 64'(req_ack), 64'(exp_ack));
                if (exp_ack != '0) begin
                    idx = find_job(infl_id);
                    if (idx >= 0) begin
                        chk("ack_hold_fields", 64'(dut_f()), 64'(job_f(exp_q[idx])));
                        exp_q.delete(idx);
                    end
                    infl = 0; mlast = infl_id; cd = 2; ack_cnt++;
                end
                exp_start = mfree && (s_req != '0);
                chk("eng_start", 64'(eng_start), 64'(exp_start));
                if (exp_start) begin
                    w = rr_winner(s_req, mlast);
                    mfree = 0; infl = 1; infl_id = w; g_iter = iter;
                    chk("grant_id", 64'(grant_id), 64'(w));
                    idx = find_job(w);
                    chk("grant_has_job", 64'(idx >= 0), 64'(1));
                    if (idx >= 0) chk("grant_fields", 64'(dut_f()), 64'(job_f(exp_q[idx])));
                    glog.push_back(w);
                    if (!eng_hold) eng_pend = (eng_delay > 0) ? eng_delay : int'($urandom_range(6, 2));
                end
                chk("busy", 64'(busy), 64'(!mfree && (cd != 1)));
                chk("timeout_err", 64'(timeout_err), 64'(exp_terr));
            end
        end
    end

    task automatic do_reset();
        @(negedge Clck);
        Reset = 1'b0;
        eng_pend = 0; eng_done = 1'b0; req = '0;
        exp_q.delete(); glog.delete();
        keep_mask = '0; p_new = 0; p_keep = 0; eng_hold = 0; eng_delay = 0;
        #1 chk("reset_outputs", all_outs(), 64'(0));
        repeat (2) @(negedge Clck);
        Reset = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (glog.size() < n && c < budget) begin @(negedge Clck); c++; end
        chk("grants_reached", 64'(glog.size() >= n), 64'(1));
    endtask

    task automatic wait_acks(input int n, input int budget);
        int c = 0;
        while (ack_cnt < n && c < budget) begin @(negedge Clck); c++; end
        chk("acks_reached", 64'(ack_cnt >= n), 64'(1));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        keep_mask = '0; p_keep = 0; p_new = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin @(negedge Clck); c++; end
        chk("drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : main
        job_t j;
        int   a0;
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        logic [FW-1:0] held;
        Reset = 1'b0; req = '0;
        req_x_start = '0; req_x_end = '0; req_y_start = '0; req_y_end = '0;
        req_cfg = '0; req_color = '0;
        repeat (3) @(negedge Clck);
        chk("por_outputs", all_outs(), 64'(0));

        // single job, fixed fields, latency and ack
        do_reset();
        eng_delay = 5;
        j = rand_job();
        j.xs = 8'd10; j.xe = 8'd20; j.ys = 7'd5; j.ye = 7'd15; j.cfg = 3'b001; j.col = 3'b110;
        a0 = ack_cnt;
        issue(0, j);
        @(posedge Clck); #2;
        chk("t1_start", 64'(eng_start), 64'(1));
        chk("t1_fields", 64'(dut_f()), 64'({8'd10, 8'd20, 7'd5, 7'd15, 3'b001, 3'b110}));
        chk("t1_grant", 64'(grant_id), 64'(0));
        @(posedge Clck); #2;
        chk("t1_start_end", 64'(eng_start), 64'(0));
        wait_acks(a0 + 1, 30);
        @(posedge Clck); #2;
        chk("t1_busy_fall", 64'(busy), 64'(0));
        drain(50);

        // all four requesting continuously
        do_reset();
        eng_delay = 2; keep_mask = '1;
        for (int i = 0; i < NR; i++) issue(i, rand_job());
        wait_grants(5, 60);
        for (int k = 0; k < 5; k++) chk("t2_order", 64'(glog[k]), 64'(exp_order[k]));
        drain(100);

        // requester 1 arrives while 2 holds req
        do_reset();
        eng_delay = 4; keep_mask = 4'b0100;
        issue(2, rand_job());
        wait_grants(1, 10);
        @(negedge Clck);
        issue(1, rand_job());
        wait_grants(3, 60);
        chk("t3_second", 64'(glog[1]), 64'(1));
        chk("t3_third", 64'(glog[2]), 64'(2));
        drain(100);

        // fields and req change under a running job
        do_reset();
        eng_delay = 6;
        a0 = ack_cnt;
        issue(3, rand_job());
        wait_grants(1, 10);
        repeat (2) @(negedge Clck);
        held = dut_f();
        req_x_start[3*XB +: XB] = ~req_x_start[3*XB +: XB];
        req_y_end[3*YB +: YB]   = ~req_y_end[3*YB +: YB];
        req_color[3*CB +: CB]   = ~req_color[3*CB +: CB];
        req[3] = 1'b0;
        repeat (2) @(negedge Clck);
        chk("t4_hold", 64'(dut_f()), 64'(held));
        wait_acks(a0 + 1, 20);
        drain(50);

        // asynchronous reset during WAIT, pending request re-served
        do_reset();
        eng_delay = 10;
        issue(2, rand_job());
        wait_grants(1, 10);
        @(posedge Clck); @(posedge Clck); #3;
        Reset = 1'b0; eng_pend = 0; eng_done = 1'b0;
        #1 chk("t5_async_reset", all_outs(), 64'(0));
        repeat (2) @(negedge Clck);
        glog.delete();
        Reset = 1'b1;
        wait_grants(1, 10);
        if (glog.size() > 0) chk("t5_regrant", 64'(glog[0]), 64'(2));
        drain(60);

        // randomized traffic
        do_reset();
        p_new = 25; p_keep = 40;
        repeat (800) @(negedge Clck);
        drain(400);

        // engine never completes
        do_reset();
        eng_hold = 1;
        a0 = ack_cnt;
        issue(0, rand_job());
`ifdef PAINT_ARB_TIMEOUT_EN
        wait_acks(a0 + 1, 40);
        repeat (3) @(negedge Clck);
        chk("t6_terr_sticky", 64'(timeout_err), 64'(1));
`else
        repeat (40) @(negedge Clck);
        chk("t6_still_busy", 64'(busy), 64'(1));
        chk("t6_no_terr", 64'(timeout_err), 64'(0));
        eng_pend = 2;
        wait_acks(a0 + 1, 10);
`endif
        eng_hold = 0;
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
